// File: rtl/VX_gpu_pkg.sv
// Shared GPU pipeline types: the commit beat record and performance-counter width.
// Supplies default NUM_THREADS / LOG2UP macros when the build does not provide them.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package VX_gpu_pkg;

    localparam int UUID_WIDTH    = 8;
    localparam int NW_WIDTH      = 2;
    localparam int XLEN          = 32;
    localparam int NUM_REGS_BITS = 5;
    localparam int SIMD_LANES    = `NUM_THREADS;
    localparam int PID_BITS      = `LOG2UP(`NUM_THREADS / SIMD_LANES);
    localparam int INFL_BITS     = 4;
    localparam int PERF_CTR_BITS = 44;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]                uuid;
        logic [NW_WIDTH-1:0]                  wid;
        logic [SIMD_LANES-1:0]                tmask;
        logic [XLEN-1:0]                      PC;
        logic                                 wb;
        logic [NUM_REGS_BITS-1:0]             rd;
        logic [SIMD_LANES-1:0][XLEN-1:0]      data;
        logic [PID_BITS-1:0]                  pid;
        logic                                 sop;
        logic                                 eop;
        logic [INFL_BITS-1:0]                 infl_id;
    } commit_data_t;

    // eop sits directly above infl_id, the last field of the packed record
    localparam int EOP_BIT = INFL_BITS;

    typedef enum logic {
        ARB_UNLOCKED,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/vx_commit_skid.sv
// Two-entry elastic buffer for commit beats; head entry is always presented on pop_data.
// On a full buffer a simultaneous push and pop keeps two entries (pop applied first).
module vx_commit_skid #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              valid,
    output logic              full
);
    logic [1:0]        count_q;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic              do_pop;

    assign pop_data = head_q;
    assign valid    = (count_q != 2'd0);
    assign full     = (count_q == 2'd2);
    assign do_pop   = pop && valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= push_data;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && do_pop) begin
                        head_q <= push_data;
                    end else if (push) begin
                        tail_q  <= push_data;
                        count_q <= 2'd2;
                    end else if (do_pop) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    if (do_pop) begin
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= push_data;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/vx_commit_arb.sv
// Round-robin commit arbiter with multi-beat packet lock, decoupled by a 2-entry skid buffer.
// Optional perf counters (perf_commits, perf_stalls) are built when VX_COMMIT_ARB_PERF_EN is defined.
module vx_commit_arb
    import VX_gpu_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int NUM_LANES  = `NUM_THREADS,
    parameter int PID_WIDTH  = `LOG2UP(`NUM_THREADS / NUM_LANES),
    parameter int DATA_W     = $bits(commit_data_t)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_INPUTS-1:0]              in_valid,
    input  logic [NUM_INPUTS-1:0][DATA_W-1:0]  in_data,
    output logic [NUM_INPUTS-1:0]              in_ready,
    output logic                               out_valid,
    output logic [DATA_W-1:0]                  out_data,
    input  logic                               out_ready
`ifdef VX_COMMIT_ARB_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]           perf_commits,
    output logic [PERF_CTR_BITS-1:0]           perf_stalls
`endif
);
    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(NUM_INPUTS - 1);

    if (DATA_W != $bits(commit_data_t) || NUM_LANES != SIMD_LANES || PID_WIDTH != PID_BITS) begin : g_bad_cfg
        $error("vx_commit_arb: NUM_LANES/PID_WIDTH/DATA_W must match VX_gpu_pkg");
    end

    arb_state_e        state_q, state_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]  lock_src_q, lock_src_d;
    logic [SEL_W-1:0]  sel;
    logic              found;
    logic              space;
    logic              push;
    logic              full;
    logic [DATA_W-1:0] push_data;

    // space uses only the registered fill level, so out_ready never reaches in_ready
    assign space = ~full;

    always_comb begin
        int idx;
        idx   = 0;
        sel   = rr_ptr_q;
        found = 1'b0;
        if (state_q == ARB_LOCKED) begin
            sel   = lock_src_q;
            found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_INPUTS; k++) begin
                idx = (int'(rr_ptr_q) + k) % NUM_INPUTS;
                if (!found && in_valid[idx]) begin
                    sel   = SEL_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (found) begin
            in_ready[sel] = space;
        end
    end

    assign push      = found && space && in_valid[sel];
    assign push_data = in_data[sel];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_src_d = lock_src_q;
        if (push) begin
            if (push_data[EOP_BIT]) begin
                state_d  = ARB_UNLOCKED;
                rr_ptr_d = sel;
            end else begin
                state_d    = ARB_LOCKED;
                lock_src_d = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_UNLOCKED;
            rr_ptr_q   <= LAST_SRC;
            lock_src_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_src_q <= lock_src_d;
        end
    end

    vx_commit_skid #(
        .DATA_W (DATA_W)
    ) skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .pop_data  (out_data),
        .valid     (out_valid),
        .full      (full)
    );

`ifdef VX_COMMIT_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_commits <= '0;
            perf_stalls  <= '0;
        end else begin
            if (out_valid && out_ready && out_data[EOP_BIT]) begin
                perf_commits <= perf_commits + PERF_CTR_BITS'(1);
            end
            if (out_valid && !out_ready) begin
                perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Bench for vx_commit_arb: table-driven corner sequences plus randomized traffic against a
// queue-based reference model of the arbitration and buffering rules.
module tb_vx_commit_arb;
    import VX_gpu_pkg::*;

    localparam int N  = 4;
    localparam int DW = $bits(commit_data_t);

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N-1:0]        in_valid;
    logic [N-1:0][DW-1:0] in_data;
    logic [N-1:0]        in_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic                out_ready;
`ifdef VX_COMMIT_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_commits;
    logic [PERF_CTR_BITS-1:0] perf_stalls;
`endif

    vx_commit_arb #(.NUM_INPUTS(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef VX_COMMIT_ARB_PERF_EN
        ,
        .perf_commits (perf_commits),
        .perf_stalls  (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] want;
        logic         ordy;
        logic [N-1:0] rdy;
        int           ov;   // -1: not checked
        int           src;  // -1: not checked
    } vec_t;

    int n_vec;
    int n_bad;
    vec_t tbl[$];

    // source drivers
    commit_data_t cur[N];
    logic         hold[N];
    int           beat_idx[N];
    int unsigned  pkt_len[N];
    int unsigned  min_len[N];
    int unsigned  max_len[N];
    int           seq[N];
    int           npkt[N];
    int           limit[N];
    logic [N-1:0] want;
    logic [N-1:0] rdy_s;

    // reference model
    commit_data_t q[$];
    bit           m_locked;
    int           m_owner;
    int           m_rr;
    longint       m_commits;
    longint       m_stalls;

    function automatic vec_t V(input logic [N-1:0] w, input logic o, input logic [N-1:0] r,
                               input int ov, input int src);
        vec_t v;
        v.want = w; v.ordy = o; v.rdy = r; v.ov = ov; v.src = src;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic commit_data_t mk_beat(input int src, input int sq, input int idx,
                                             input int unsigned len);
        commit_data_t b;
        b.uuid    = {2'(src), 6'(sq)};
        b.wid     = NW_WIDTH'($urandom);
        b.tmask   = SIMD_LANES'($urandom);
        b.PC      = $urandom;
        b.wb      = 1'($urandom);
        b.rd      = NUM_REGS_BITS'($urandom);
        for (int l = 0; l < SIMD_LANES; l++) b.data[l] = $urandom;
        b.pid     = PID_BITS'(idx);
        b.sop     = (idx == 0);
        b.eop     = (idx == int'(len) - 1);
        b.infl_id = INFL_BITS'($urandom);
        return b;
    endfunction

    // Which source the arbitration rules allow to transfer this cycle.
    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        bit space;
        r = '0;
        space = (q.size() < 2);
        if (m_locked) begin
            r[m_owner] = space;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int s;
                s = (m_rr + k) % N;
                if (in_valid[s]) begin
                    r[s] = space;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!hold[i] && want[i] && (beat_idx[i] != 0 || npkt[i] < limit[i])) begin
                if (beat_idx[i] == 0) begin
                    pkt_len[i] = $urandom_range(max_len[i], min_len[i]);
                    npkt[i]++;
                end
                cur[i]  = mk_beat(i, seq[i], beat_idx[i], pkt_len[i]);
                hold[i] = 1'b1;
            end
            in_valid[i] = hold[i];
            in_data[i]  = cur[i];
        end
    endtask

    task automatic tick(input bit use_t, input vec_t v);
        logic [N-1:0] er;
        commit_data_t od;
        @(negedge clk);
        er    = m_ready();
        rdy_s = in_ready;
        od    = out_data;
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) chk("out_data", out_data, q[0]);
`ifdef VX_COMMIT_ARB_PERF_EN
        chk("perf_commits_run", perf_commits, m_commits);
        chk("perf_stalls_run", perf_stalls, m_stalls);
`endif
        if (use_t) begin
            chk("tbl_in_ready", in_ready, v.rdy);
            if (v.ov >= 0) chk("tbl_out_valid", out_valid, v.ov[0]);
            if (v.src >= 0) chk("tbl_out_src", od.uuid[7:6], v.src[1:0]);
        end
        @(posedge clk);
        if (q.size() > 0 && !out_ready) m_stalls++;
        if (q.size() > 0 && out_ready) begin
            if (q[0].eop) m_commits++;
            q.delete(0);
        end
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && er[i]) begin
                q.push_back(cur[i]);
                if (cur[i].eop) begin
                    m_locked = 1'b0;
                    m_rr     = i;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = i;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (hold[i] && rdy_s[i]) begin
                hold[i] = 1'b0;
                seq[i]++;
                beat_idx[i] = cur[i].eop ? 0 : beat_idx[i] + 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = '0;
        want     = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        q.delete();
        m_locked  = 1'b0;
        m_owner   = 0;
        m_rr      = N - 1;
        m_commits = 0;
        m_stalls  = 0;
        for (int i = 0; i < N; i++) begin
            hold[i] = 1'b0; beat_idx[i] = 0; npkt[i] = 0; seq[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic run_table();
        foreach (tbl[r]) begin
            want      = tbl[r].want;
            out_ready = tbl[r].ordy;
            drive();
            tick(1'b1, tbl[r]);
        end
    endtask

    task automatic set_lens(input int unsigned lo, input int unsigned hi);
        for (int i = 0; i < N; i++) begin
            min_len[i] = lo; max_len[i] = hi; limit[i] = 1 << 30;
        end
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        reset_n = 1'b1; out_ready = 1'b1; want = '0; in_valid = '0; in_data = '0;
        set_lens(1, 1);
        #2;

        // round robin over single-beat packets
        do_reset();
        tbl.delete();
        tbl.push_back(V(4'b1111, 1'b1, 4'b0001, 0, -1));
        tbl.push_back(V(4'b1111, 1'b1, 4'b0010, 1, 0));
        tbl.push_back(V(4'b1111, 1'b1, 4'b0100, 1, 1));
        tbl.push_back(V(4'b1111, 1'b1, 4'b1000, 1, 2));
        tbl.push_back(V(4'b1111, 1'b1, 4'b0001, 1, 3));
        tbl.push_back(V(4'b1111, 1'b1, 4'b0010, 1, 0));
        run_table();

        // packet lock: source 2 sends 3 beats with a 2-cycle gap after the first
        do_reset();
        min_len[2] = 3; max_len[2] = 3;
        tbl.delete();
        tbl.push_back(V(4'b0100, 1'b1, 4'b0100, 0, -1));
        tbl.push_back(V(4'b1011, 1'b1, 4'b0100, 1, 2));
        tbl.push_back(V(4'b1011, 1'b1, 4'b0100, 0, -1));
        tbl.push_back(V(4'b1111, 1'b1, 4'b0100, 0, -1));
        tbl.push_back(V(4'b1111, 1'b1, 4'b0100, 1, 2));
        tbl.push_back(V(4'b1111, 1'b1, 4'b1000, 1, 2));
        run_table();
        set_lens(1, 1);

        // backpressure: 5 cycles of out_ready low admit exactly two beats
        do_reset();
        tbl.delete();
        tbl.push_back(V(4'b1111, 1'b0, 4'b0001, 0, -1));
        tbl.push_back(V(4'b1111, 1'b0, 4'b0010, 1, 0));
        tbl.push_back(V(4'b1111, 1'b0, 4'b0000, 1, 0));
        tbl.push_back(V(4'b1111, 1'b0, 4'b0000, 1, 0));
        tbl.push_back(V(4'b1111, 1'b0, 4'b0000, 1, 0));
        tbl.push_back(V(4'b1111, 1'b1, 4'b0000, 1, 0));
        tbl.push_back(V(4'b1111, 1'b1, 4'b0100, 1, 1));
        tbl.push_back(V(4'b1111, 1'b1, 4'b1000, 1, 2));
        run_table();
        for (int c = 0; c < 10; c++) begin
            drive();
            tick(1'b0, '0);
        end

        // reset while locked with one beat buffered
        do_reset();
        min_len[2] = 3; max_len[2] = 3;
        want = 4'b0100; out_ready = 1'b0;
        drive();
        tick(1'b0, '0);
        chk("pre_reset_out_valid", out_valid, 1);
        do_reset();
        set_lens(1, 1);
        tbl.delete();
        tbl.push_back(V(4'b1111, 1'b1, 4'b0001, 0, -1));
        tbl.push_back(V(4'b1111, 1'b1, 4'b0010, 1, 0));
        run_table();

        // perf stream: 10 single-beat packets, 3 stall cycles
        do_reset();
        for (int i = 1; i < N; i++) limit[i] = 0;
        limit[0] = 10;
        want = 4'b0001;
        for (int c = 0; c < 25; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            drive();
            tick(1'b0, '0);
        end
        chk("stream_drained", q.size(), 0);
`ifdef VX_COMMIT_ARB_PERF_EN
        chk("perf_commits", perf_commits, 10);
        chk("perf_stalls", perf_stalls, 3);
`endif

        // randomized traffic with multi-beat packets and gaps
        do_reset();
        set_lens(1, 3);
        for (int c = 0; c < 3000; c++) begin
            want      = N'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            drive();
            tick(1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vx_commit_arb.md
# vx_commit_arb

Multi-channel commit arbiter that merges `NUM_INPUTS` commit streams into one commit stream toward the writeback/scoreboard stage. Multi-beat commit packets (sop…eop, e.g. lane-split ALU/LSU results) are kept atomic by a packet lock. Arbitration between packets is round-robin. The output is decoupled through a 2-entry skid buffer, so no combinational path exists from `out_ready` to any `in_ready`.

## Interface
Parameters:
- `NUM_INPUTS`, 4: number of commit sources (≥1).
- `NUM_LANES`, `` `NUM_THREADS ``: lanes per beat.
- `PID_WIDTH`, `` `LOG2UP(`NUM_THREADS/NUM_LANES) ``: packet-part id width.
- `DATA_W`, `$bits(commit_data_t)`: derived beat width; do not override.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  `NUM_INPUTS`  per-source beat valid.
- `in_data`  in  `NUM_INPUTS`×`DATA_W`  per-source `commit_data_t` beat.
- `in_ready`  out  `NUM_INPUTS`  per-source accept.
- `out_valid`  out  1  merged beat valid.
- `out_data`  out  `DATA_W`  merged `commit_data_t` beat.
- `out_ready`  in  1  downstream accept.
- `perf_commits`  out  `PERF_CTR_BITS`  count of eop beats delivered (present only with `VX_COMMIT_ARB_PERF_EN`).
- `perf_stalls`  out  `PERF_CTR_BITS`  count of cycles with `out_valid & ~out_ready` (present only with `VX_COMMIT_ARB_PERF_EN`).

## Operation
- A transfer occurs when valid and ready are both high in the same cycle.
- Valid must not drop, and data must not change, until the transfer occurs. This applies on both sides.
- `space` = skid buffer holds fewer than 2 entries, computed from registered count only.
- **Unlocked:**
  - Grant goes to the first valid input searching from `rr_ptr+1` (mod `NUM_INPUTS`).
  - `in_ready[g] = space`; all other `in_ready` = 0.
- **Locked** to source L:
  - `in_ready[L] = space`; all others 0, even while `in_valid[L]` = 0.
- **Lock set:** an accepted beat has `eop` = 0. Lock to that source; `rr_ptr` is unchanged.
- **Lock clear:** an accepted beat has `eop` = 1. Unlock and set `rr_ptr` = that source.
- A single-beat packet (`sop` = `eop` = 1) never locks.
- The `sop` field is passed through only and is not interpreted.
- Beats leave in acceptance order. `out_data` is the head entry, unmodified.
- **Simultaneous push and pop** on a full buffer: pop first, so the count stays 2. `space` was 0, so push is impossible in that cycle anyway.
- **Reset values:**
  - `out_valid` = 0, `out_data` = 0.
  - buffer count = 0, lock = 0.
  - `rr_ptr` = `NUM_INPUTS-1`, so source 0 has first priority.
  - perf counters = 0.
- Reset mid-packet drops the buffered beats and the lock. Upstream units are reset by the same `reset_n`.
- **`NUM_INPUTS` = 1:** the arbiter degenerates to pass-through. The lock logic remains but has no effect.

## Timing
- Latency: a beat accepted in cycle t is presented with `out_valid` = 1 in cycle t+1 at the earliest.
- Throughput: 1 beat/cycle sustained while `out_ready` = 1.
- After 2 consecutive cycles with `out_ready` = 0 and the buffer full, all `in_ready` = 0 from the next cycle. Ready returns 1 cycle after a pop.
- `in_ready` depends only on registers and `in_valid`. There is no combinational path from `out_ready`.
- Perf counters wrap modulo 2^`PERF_CTR_BITS`.

## Configuration
- `VX_COMMIT_ARB_PERF_EN` defined:
  - `perf_commits` and `perf_stalls` ports and counters exist.
  - Increments happen on the `clk` edge following the qualifying cycle.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- `commit_data_t` lives in `VX_gpu_pkg`, parameterised via package-level widths. Fields: `uuid`, `wid`, `tmask`, `PC`, `wb`, `rd`, `data`, `pid`, `sop`, `eop`, `infl_id`.
- `PERF_CTR_BITS` (44) also lives in `VX_gpu_pkg`.
- One sub-module, `vx_commit_skid`: 2-entry elastic buffer, async active-low reset, ports push/pop/full/data. The arbiter and lock FSM (UNLOCKED/LOCKED + `rr_ptr`) stay in `vx_commit_arb`.

## Test plan
- **Reset, then round-robin:** after reset, all 4 inputs valid with single-beat packets, `out_ready` = 1 → output order 0,1,2,3,0, with the first `out_valid` one cycle after the first acceptance.
- **Packet lock:**
  - Source 2 sends a 3-beat packet (`eop` = 0,0,1) and deasserts `in_valid` for 2 cycles between beats 1 and 2.
  - Sources 0, 1 and 3 are valid throughout.
  - Required: `in_ready[0,1,3]` = 0 until source 2's `eop` beat is accepted; next grant goes to 3.
- **Backpressure:** `out_ready` = 0 for 5 cycles with continuous input → exactly 2 beats accepted; no loss or duplication after `out_ready` = 1.
- **Reset mid-packet:** `reset_n` low while locked with 1 beat buffered → `out_valid` = 0 immediately; after release, source 0 wins first.
- **Perf counters** (macro defined): 10 eop beats with 3 stall cycles → `perf_commits` = 10, `perf_stalls` = 3. With the macro undefined, the same stream yields identical `out_data`.
